// File: rtl/seg_scan_decoder.sv
// Seven-segment scan bus monitor: debounces each digit, decodes it, emits frames.
// Optional input synchroniser: define SEG_SCAN_DECODER_SYNC_EN.
module seg_scan_decoder #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            seg_in,
    input  logic [DIGITS-1:0]     dig_sel,
    output logic [4*DIGITS-1:0]   number_out,
    output logic [DIGITS-1:0]     blank_out,
    output logic [DIGITS-1:0]     error_out,
    output logic                  frame_valid,
    input  logic                  frame_ready,
    output logic                  overrun
);

    localparam int SW = DIGITS + 7;
    localparam logic [7:0] LAST = 8'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        T_UNSTABLE,
        T_COUNT,
        T_HELD
    } trk_t;

    typedef enum logic {
        O_EMPTY,
        O_FULL
    } ofsm_t;

    logic [DIGITS-1:0] dsel;
    logic [6:0]        seg;

`ifdef SEG_SCAN_DECODER_SYNC_EN
    logic [SW-1:0] sync1;
    logic [SW-1:0] sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {dig_sel, seg_in};
            sync2 <= sync1;
        end
    end

    assign {dsel, seg} = sync2;
`else
    assign dsel = dig_sel;
    assign seg  = seg_in;
`endif

    logic [SW-1:0] smp;
    logic [SW-1:0] prev;
    logic          armed;
    logic          changed;
    logic          onehot;
    logic          hit;
    trk_t          st;
    trk_t          st_n;
    logic [7:0]    cnt;
    logic [7:0]    cnt_n;
    logic          cap;

    assign smp     = {dsel, seg};
    assign changed = (smp != prev);
    assign onehot  = (dsel != '0) && ((dsel & (dsel - DIGITS'(1))) == '0);
    assign hit     = ((cnt + 8'd1) == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st    <= T_UNSTABLE;
            cnt   <= '0;
            prev  <= '0;
            armed <= 1'b0;
        end else begin
            st    <= st_n;
            cnt   <= cnt_n;
            prev  <= smp;
            armed <= 1'b1;
        end
    end

    // The first sample after reset only loads prev; nothing is judged yet.
    always_comb begin
        st_n  = st;
        cnt_n = cnt;
        if (armed) begin
            if (changed) begin
                cnt_n = '0;
                if (!onehot)
                    st_n = T_UNSTABLE;
                else if (LAST == 8'd0)
                    st_n = T_HELD;
                else
                    st_n = T_COUNT;
            end else if (st == T_COUNT) begin
                cnt_n = cnt + 8'd1;
                if (hit)
                    st_n = T_HELD;
            end
        end
    end

    always_comb begin
        cap = 1'b0;
        if (armed && onehot) begin
            if (changed)
                cap = (LAST == 8'd0);
            else
                cap = (st == T_COUNT) && hit;
        end
    end

    logic [3:0] dnum;
    logic       dblank;
    logic       derr;

    always_comb begin
        dnum   = 4'hE;
        dblank = 1'b0;
        derr   = 1'b0;
        case (seg)
            7'b0111111: dnum = 4'd0;
            7'b0000110: dnum = 4'd1;
            7'b1011011: dnum = 4'd2;
            7'b1001111: dnum = 4'd3;
            7'b1100110: dnum = 4'd4;
            7'b1101101: dnum = 4'd5;
            7'b1111101: dnum = 4'd6;
            7'b0000111: dnum = 4'd7;
            7'b1111111: dnum = 4'd8;
            7'b1101111: dnum = 4'd9;
            7'b0000000: begin
                dnum   = 4'hF;
                dblank = 1'b1;
            end
            default: derr = 1'b1;
        endcase
    end

    logic [4*DIGITS-1:0] stg_num;
    logic [4*DIGITS-1:0] stg_num_n;
    logic [DIGITS-1:0]   stg_bl;
    logic [DIGITS-1:0]   stg_bl_n;
    logic [DIGITS-1:0]   stg_er;
    logic [DIGITS-1:0]   stg_er_n;
    logic [DIGITS-1:0]   mask;
    logic [DIGITS-1:0]   mask_n;
    logic                done;

    always_comb begin
        stg_num_n = stg_num;
        stg_bl_n  = stg_bl;
        stg_er_n  = stg_er;
        mask_n    = mask;
        if (cap) begin
            mask_n = mask | dsel;
            for (int i = 0; i < DIGITS; i++) begin
                if (dsel[i]) begin
                    stg_num_n[4*i +: 4] = dnum;
                    stg_bl_n[i]         = dblank;
                    stg_er_n[i]         = derr;
                end
            end
        end
    end

    assign done = cap && (mask_n == '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_num <= '0;
            stg_bl  <= '0;
            stg_er  <= '0;
            mask    <= '0;
        end else begin
            stg_num <= stg_num_n;
            stg_bl  <= stg_bl_n;
            stg_er  <= stg_er_n;
            mask    <= done ? '0 : mask_n;
        end
    end

    ofsm_t               ost;
    ofsm_t               ost_n;
    logic                ovr_q;
    logic                ovr_n;
    logic                load;
    logic [4*DIGITS-1:0] num_q;
    logic [DIGITS-1:0]   bl_q;
    logic [DIGITS-1:0]   er_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ost   <= O_EMPTY;
            ovr_q <= 1'b0;
            num_q <= '0;
            bl_q  <= '0;
            er_q  <= '0;
        end else begin
            ost   <= ost_n;
            ovr_q <= ovr_n;
            if (load) begin
                num_q <= stg_num_n;
                bl_q  <= stg_bl_n;
                er_q  <= stg_er_n;
            end
        end
    end

    always_comb begin
        ost_n = ost;
        ovr_n = ovr_q;
        unique case (ost)
            O_EMPTY: begin
                if (done)
                    ost_n = O_FULL;
            end
            O_FULL: begin
                if (frame_ready) begin
                    ovr_n = 1'b0;
                    if (!done)
                        ost_n = O_EMPTY;
                end else if (done) begin
                    ovr_n = 1'b1;
                end
            end
        endcase
    end

    // A completed frame loads only when the output slot is free this edge.
    always_comb begin
        load = done && ((ost == O_EMPTY) || frame_ready);
    end

    assign frame_valid = (ost == O_FULL);
    assign overrun     = ovr_q;
    assign number_out  = num_q;
    assign blank_out   = bl_q;
    assign error_out   = er_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder with DIGITS=4, STABLE_CYCLES=8.
module tb_seg_scan_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  seg_in = '0;
    logic [3:0]  dig_sel = '0;
    logic [15:0] number_out;
    logic [3:0]  blank_out;
    logic [3:0]  error_out;
    logic        frame_valid;
    logic        frame_ready = 1'b0;
    logic        overrun;

    int pass_cnt = 0;
    int total_cnt = 0;

    seg_scan_decoder #(.DIGITS(4), .STABLE_CYCLES(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .dig_sel     (dig_sel),
        .number_out  (number_out),
        .blank_out   (blank_out),
        .error_out   (error_out),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [27:0] segs;
        logic [15:0] num;
        logic [3:0]  bl;
        logic [3:0]  er;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp)
            pass_cnt++;
        else
            $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic hold(input logic [3:0] d, input logic [6:0] p, input int n);
        dig_sel = d;
        seg_in  = p;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic scan(input logic [27:0] s);
        for (int i = 0; i < 4; i++)
            hold(4'b0001 << i, s[7*i +: 7], 10);
    endtask

    task automatic pulse_ready();
        frame_ready = 1'b1;
        @(posedge clk);
        #1;
        frame_ready = 1'b0;
    endtask

    initial begin
        vecs[0] = '{{7'h66, 7'h4F, 7'h5B, 7'h06}, 16'h4321, 4'b0000, 4'b0000};
        vecs[1] = '{{7'h6F, 7'h00, 7'h55, 7'h6D}, 16'h9FE5, 4'b0100, 4'b0010};
        vecs[2] = '{{7'h7F, 7'h07, 7'h7D, 7'h3F}, 16'h8760, 4'b0000, 4'b0000};
        vecs[3] = '{{7'h00, 7'h07, 7'h7E, 7'h4F}, 16'hF7E3, 4'b1000, 4'b0010};

        #2;
        chk("rst_num", number_out, 0);
        chk("rst_valid", frame_valid, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_blank_err", {blank_out, error_out}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        hold(4'b0000, 7'h00, 3);

        // capture latency with ready held high
        frame_ready = 1'b1;
        hold(4'b0001, 7'h06, 10);
        hold(4'b0010, 7'h5B, 10);
        hold(4'b0100, 7'h4F, 10);
        hold(4'b1000, 7'h66, 7);
        chk("lat_valid_early", frame_valid, 0);
        @(posedge clk);
        #1;
        chk("lat_valid", frame_valid, 1);
        chk("lat_num", number_out, 16'h4321);
        chk("lat_blank_err", {blank_out, error_out}, 0);
        @(posedge clk);
        #1;
        chk("lat_handshake", frame_valid, 0);
        frame_ready = 1'b0;

        for (int v = 0; v < 4; v++) begin
            scan(vecs[v].segs);
            chk($sformatf("tbl%0d_valid", v), frame_valid, 1);
            chk($sformatf("tbl%0d_num", v), number_out, vecs[v].num);
            chk($sformatf("tbl%0d_blank", v), blank_out, vecs[v].bl);
            chk($sformatf("tbl%0d_err", v), error_out, vecs[v].er);
            pulse_ready();
            chk($sformatf("tbl%0d_ack", v), frame_valid, 0);
        end

        // glitch on the last digit
        hold(4'b0001, 7'h3F, 10);
        hold(4'b0010, 7'h3F, 10);
        hold(4'b0100, 7'h3F, 10);
        hold(4'b1000, 7'h6F, 7);
        chk("gl_run7", frame_valid, 0);
        hold(4'b1000, 7'h06, 1);
        hold(4'b1000, 7'h6F, 7);
        chk("gl_run8_early", frame_valid, 0);
        @(posedge clk);
        #1;
        chk("gl_valid", frame_valid, 1);
        chk("gl_num", number_out, 16'h9000);
        pulse_ready();

        // illegal digit selects must not capture
        hold(4'b0001, 7'h06, 10);
        hold(4'b0010, 7'h5B, 10);
        hold(4'b0100, 7'h4F, 10);
        hold(4'b0000, 7'h06, 20);
        hold(4'b0110, 7'h5B, 20);
        chk("ill_valid", frame_valid, 0);
        hold(4'b1000, 7'h66, 10);
        chk("ill_valid_after", frame_valid, 1);
        chk("ill_num", number_out, 16'h4321);
        pulse_ready();

        // overrun and same-edge reload
        scan(vecs[0].segs);
        chk("ov_first", number_out, 16'h4321);
        chk("ov_first_flag", overrun, 0);
        scan(vecs[2].segs);
        chk("ov_frozen", number_out, 16'h4321);
        chk("ov_flag", overrun, 1);
        chk("ov_valid", frame_valid, 1);
        pulse_ready();
        chk("ov_ack_valid", frame_valid, 0);
        chk("ov_ack_flag", overrun, 0);
        scan(vecs[0].segs);
        scan(vecs[2].segs);
        chk("ov2_flag", overrun, 1);
        hold(4'b0001, 7'h6D, 10);
        hold(4'b0010, 7'h55, 10);
        hold(4'b0100, 7'h00, 10);
        hold(4'b1000, 7'h6F, 7);
        frame_ready = 1'b1;
        @(posedge clk);
        #1;
        frame_ready = 1'b0;
        chk("se_valid", frame_valid, 1);
        chk("se_num", number_out, 16'h9FE5);
        chk("se_flag", overrun, 0);
        pulse_ready();
        chk("se_ack", frame_valid, 0);

        // asynchronous reset mid-count with a frame pending
        scan(vecs[1].segs);
        chk("rs_pending", frame_valid, 1);
        hold(4'b0001, 7'h7F, 4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rs_num", number_out, 0);
        chk("rs_valid", frame_valid, 0);
        chk("rs_blank_err", {blank_out, error_out}, 0);
        chk("rs_ovr", overrun, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        hold(4'b0000, 7'h00, 3);
        scan(vecs[3].segs);
        chk("rs_new_valid", frame_valid, 1);
        chk("rs_new_num", number_out, 16'hF7E3);
        chk("rs_new_blank", blank_out, 4'b1000);
        chk("rs_new_err", error_out, 4'b0010);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
